alu_exec_pipe: RTL and testbench

Parametrised, pipelined integer execute unit for the MIPS pipeline: accepts one ALU operation per cycle under a valid/ready handshake. Produces WIDTH-bit results after STAGES cycles.
- Generalises the fixed 32-bit, NOP-padded execute path.
- Adds unsigned compare (SLTU), shifts, signed-overflow detection, back-pressure and flush.
- Sits between decode/operand fetch and write-back; its out_dest and out_result feed the register-file write port.

---
 rtl/alu_exec_pipe.sv | 134 +++++++++++++
 tb/tb_alu_exec_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_pipe.sv
// ----------------------------------------------------------------------------
// alu_exec_pipe : pipelined integer execute unit with valid/ready, stall, flush
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module alu_exec_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [4:0]       in_dest,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [4:0]       out_dest,
  output logic             out_ovf,
  output logic             out_illegal,
  output logic             busy
);

  localparam int SHAMT_W = $clog2(WIDTH);

  logic [STAGES-1:0] valid_q, valid_d;
  logic [WIDTH-1:0]  result_q [STAGES];
  logic [WIDTH-1:0]  result_d [STAGES];
  logic [4:0]        dest_q   [STAGES];
  logic [4:0]        dest_d   [STAGES];
  logic [STAGES-1:0] ovf_q, ovf_d;
  logic [STAGES-1:0] ill_q, ill_d;

  logic               w_adv;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic [SHAMT_W-1:0] w_shamt;
  logic [WIDTH-1:0]   w_alu_res;
  logic               w_alu_ovf;
  logic               w_alu_ill;

  // Global stall: the whole pipe moves only when the last stage can drain.
  assign w_adv    = !valid_q[STAGES-1] | out_ready;
  assign in_ready = w_adv & !flush;

  assign w_sum   = in_a + in_b;
  assign w_diff  = in_a - in_b;
  assign w_shamt = in_b[SHAMT_W-1:0];

  always_comb begin
    w_alu_res = '0;
    w_alu_ovf = 1'b0;
    w_alu_ill = 1'b0;
    case (in_op)
      4'd0: begin
        w_alu_res = w_sum;
        w_alu_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      4'd1: begin
        w_alu_res = w_diff;
        w_alu_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      4'd2:  w_alu_res = in_a & in_b;
      4'd3:  w_alu_res = in_a | in_b;
      4'd4:  w_alu_res = in_a ^ in_b;
      4'd5:  w_alu_res = ~(in_a | in_b);
      4'd6:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      4'd7:  w_alu_res = {{(WIDTH-1){1'b0}}, (in_a < in_b)};
      4'd8:  w_alu_res = in_a << w_shamt;
      4'd9:  w_alu_res = in_a >> w_shamt;
      4'd10: w_alu_res = $signed(in_a) >>> w_shamt;
      default: w_alu_ill = 1'b1;
    endcase
  end

  always_comb begin
    valid_d  = valid_q;
    result_d = result_q;
    dest_d   = dest_q;
    ovf_d    = ovf_q;
    ill_d    = ill_q;
    if (w_adv) begin
      valid_d[0]  = in_valid & in_ready;
      result_d[0] = w_alu_res;
      dest_d[0]   = in_dest;
      ovf_d[0]    = w_alu_ovf;
      ill_d[0]    = w_alu_ill;
      for (int i = 1; i < STAGES; i++) begin
        valid_d[i]  = valid_q[i-1];
        result_d[i] = result_q[i-1];
        dest_d[i]   = dest_q[i-1];
        ovf_d[i]    = ovf_q[i-1];
        ill_d[i]    = ill_q[i-1];
      end
    end
    // Flush only kills valid bits; payload left behind is never observed.
    if (flush) begin
      valid_d = '0;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      ovf_q   <= '0;
      ill_q   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        result_q[i] <= '0;
        dest_q[i]   <= '0;
      end
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      dest_q   <= dest_d;
      ovf_q    <= ovf_d;
      ill_q    <= ill_d;
    end
  end

  assign out_valid   = valid_q[STAGES-1];
  assign out_result  = result_q[STAGES-1];
  assign out_dest    = dest_q[STAGES-1];
  assign out_ovf     = ovf_q[STAGES-1];
  assign out_illegal = ill_q[STAGES-1];
  assign busy        = |valid_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_pipe.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_pipe : directed self-checking bench for alu_exec_pipe (STAGES=4)
// Revision 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_alu_exec_pipe;

  localparam int W = 32;
  localparam int S = 4;

  logic         clk1 = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         flush = 1'b0;
  logic         out_ready = 1'b0;
  logic [3:0]   in_op = '0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic [4:0]   in_dest = '0;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_result;
  logic [4:0]   out_dest;
  logic         out_ovf;
  logic         out_illegal;
  logic         busy;

  int checks = 0;
  int errors = 0;

  alu_exec_pipe #(.WIDTH(W), .STAGES(S)) dut (
    .clk1       (clk1),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_dest    (in_dest),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_dest   (out_dest),
    .out_ovf    (out_ovf),
    .out_illegal(out_illegal),
    .busy       (busy)
  );

  always #5 clk1 = ~clk1;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op from a negedge with the output side ready, then verify latency and payload.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] d, input logic [31:0] er,
                        input logic eo, input logic ei);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; in_dest = d; out_ready = 1'b1;
    #1 check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk1);
    @(negedge clk1);
    in_valid = 1'b0;
    for (int k = 0; k < S - 1; k++) begin
      check({tag, "_early"}, 64'(out_valid), 64'd0);
      @(negedge clk1);
    end
    check({tag, "_valid"},   64'(out_valid),   64'd1);
    check({tag, "_result"},  64'(out_result),  64'(er));
    check({tag, "_dest"},    64'(out_dest),    64'(d));
    check({tag, "_ovf"},     64'(out_ovf),     64'(eo));
    check({tag, "_illegal"}, 64'(out_illegal), 64'(ei));
    @(negedge clk1);
  endtask

  initial begin
    logic [3:0] pat;
    int sent, recv, cyc;
    logic seen;

    // Reset state
    @(posedge clk1);
    @(negedge clk1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(out_result), 64'd0);
    check("rst_dest",      64'(out_dest), 64'd0);
    check("rst_ovf",       64'(out_ovf), 64'd0);
    check("rst_illegal",   64'(out_illegal), 64'd0);
    check("rst_busy",      64'(busy), 64'd0);
    rst_n = 1'b1;
    #1 check("rst_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk1);

    // Compares, shifts, logic ops
    run_op("slt_1_2",   4'd6,  32'd1,        32'd2,  5'd3,  32'd1,        1'b0, 1'b0);
    run_op("slt_2_1",   4'd6,  32'd2,        32'd1,  5'd4,  32'd0,        1'b0, 1'b0);
    run_op("slt_neg",   4'd6,  32'hFFFFFFFF, 32'd1,  5'd5,  32'd1,        1'b0, 1'b0);
    run_op("sltu_big",  4'd7,  32'hFFFFFFFF, 32'd1,  5'd6,  32'd0,        1'b0, 1'b0);
    run_op("sra",       4'd10, 32'h80000000, 32'd4,  5'd7,  32'hF8000000, 1'b0, 1'b0);
    run_op("srl",       4'd9,  32'h80000000, 32'd4,  5'd8,  32'h08000000, 1'b0, 1'b0);
    run_op("sll_upper", 4'd8,  32'd1,        32'h25, 5'd9,  32'h00000020, 1'b0, 1'b0);
    run_op("and",       4'd2,  32'hF0F0,     32'hFF00, 5'd10, 32'hF000,   1'b0, 1'b0);
    run_op("or",        4'd3,  32'hF0F0,     32'hFF00, 5'd11, 32'hFFF0,   1'b0, 1'b0);
    run_op("xor",       4'd4,  32'hF0F0,     32'hFF00, 5'd12, 32'h0FF0,   1'b0, 1'b0);
    run_op("nor",       4'd5,  32'h0F0F0F0F, 32'hF0F0F0F0, 5'd13, 32'h0,  1'b0, 1'b0);

    // Arithmetic, overflow, illegal
    run_op("add_ovf",   4'd0,  32'h7FFFFFFF, 32'd1,  5'd14, 32'h80000000, 1'b1, 1'b0);
    run_op("sub_ovf",   4'd1,  32'h80000000, 32'd1,  5'd15, 32'h7FFFFFFF, 1'b1, 1'b0);
    run_op("add_5_3",   4'd0,  32'd5,        32'd3,  5'd16, 32'd8,        1'b0, 1'b0);
    run_op("add_wrap",  4'd0,  32'hFFFFFFFF, 32'd1,  5'd17, 32'd0,        1'b0, 1'b0);
    run_op("sub_0_1",   4'd1,  32'd0,        32'd1,  5'd18, 32'hFFFFFFFF, 1'b0, 1'b0);
    run_op("illegal13", 4'd13, 32'd5,        32'd3,  5'd19, 32'd0,        1'b0, 1'b1);

    // Streaming with back-pressure pattern 1,0,0,1
    pat = 4'b1001;
    sent = 0; recv = 0; cyc = 0;
    while ((recv < 8 || sent < 8) && cyc < 200) begin
      out_ready = pat[cyc % 4];
      in_valid  = (sent < 8);
      in_op     = 4'd0;
      in_a      = 32'(sent);
      in_b      = 32'd100;
      in_dest   = 5'(sent + 1);
      #1;
      if (out_valid && !out_ready) begin
        check("stream_stall_in_ready", 64'(in_ready), 64'd0);
        check("stream_stall_result", 64'(out_result), 64'(100 + recv));
      end
      if (out_valid && out_ready) begin
        check("stream_result", 64'(out_result), 64'(100 + recv));
        check("stream_dest",   64'(out_dest),   64'(recv + 1));
        recv++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk1);
      cyc++;
    end
    in_valid = 1'b0;
    check("stream_count", 64'(recv), 64'd8);
    check("stream_busy_end", 64'(busy), 64'd0);

    // Fill the pipe, then flush
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_op = 4'd0; in_a = 32'(i + 10); in_b = 32'd0; in_dest = 5'(20 + i);
      @(negedge clk1);
    end
    in_valid = 1'b0;
    #1;
    check("fill_busy",      64'(busy), 64'd1);
    check("fill_out_valid", 64'(out_valid), 64'd1);
    check("fill_in_ready",  64'(in_ready), 64'd0);
    check("fill_head",      64'(out_result), 64'd10);
    flush = 1'b1; in_valid = 1'b1; in_a = 32'd77; out_ready = 1'b1;
    #1 check("flush_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk1);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk1);
      seen = seen | out_valid;
    end
    check("flush_no_ghost", 64'(seen), 64'd0);
    run_op("post_flush", 4'd0, 32'd5, 32'd3, 5'd21, 32'd8, 1'b0, 1'b0);

    // Asynchronous reset with three ops in flight
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 4'd0; in_a = 32'd1; in_b = 32'd2; in_dest = 5'd1;
    @(negedge clk1);
    in_dest = 5'd2;
    @(negedge clk1);
    in_dest = 5'd3;
    @(posedge clk1);
    #2;
    check("arst_busy_before", 64'(busy), 64'd1);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check("arst_busy",      64'(busy), 64'd0);
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_result",    64'(out_result), 64'd0);
    check("arst_dest",      64'(out_dest), 64'd0);
    @(negedge clk1);
    rst_n = 1'b1;
    #1 check("arst_in_ready", 64'(in_ready), 64'd1);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk1);
      seen = seen | out_valid;
    end
    check("arst_no_stale", 64'(seen), 64'd0);
    run_op("post_arst", 4'd1, 32'd5, 32'd3, 5'd22, 32'd2, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
